rx_peak_report_queue: RTL
=========================

Name: rx_peak_report_queue

Overview:
- Sits directly downstream of rx_top_level, on its peak-report outputs (o_trigger_arm, o_sample_arm, o_received_seq, o_time_arm).
- Acknowledges each peak report by driving rx_top_level's iresult_acquired_arm.
- Queues each accepted report (peak value, sequence id, timestamp) in a small FIFO.
- Presents the head report to the ARM-side reader over a valid/ready handshake and counts reports dropped because the queue was full.

Parameters:
- DEPTH, 8, number of queued reports (power of two, ≥2)
- SAMPLE_W, 41, peak value width (signed)
- SEQ_W, 4, received-sequence id width
- TIME_W, 32, timestamp width
- OVF_W, 16, overflow counter width

Ports:
- crx_clk  in  1  clock; all logic is on its rising edge
- rrx_rst  in  1  reset; synchronous, active-low
- erx_en  in  1  capture enable
- i_trigger_peak  in  1  from o_trigger_arm; held high until acknowledged
- i_sample_peak  in  SAMPLE_W  from o_sample_arm
- i_seq_peak  in  SEQ_W  from o_received_seq
- i_time_peak  in  TIME_W  from o_time_arm
- o_result_acquired  out  1  to iresult_acquired_arm; one-cycle acknowledge pulse
- o_rep_valid  out  1  head entry valid
- i_rep_ready  in  1  reader accepts head
- o_rep_sample  out  SAMPLE_W  head peak value
- o_rep_seq  out  SEQ_W  head sequence id
- o_rep_time  out  TIME_W  head timestamp
- o_rep_count  out  clog2(DEPTH+1)  occupancy
- i_clear_ovf  in  1  clear overflow counter
- o_overflow_cnt  out  OVF_W  dropped-report count, saturating

Behaviour:
- Reset (rrx_rst==0 at an edge):
  - FSM goes to IDLE.
  - Pointers and o_rep_count go to 0.
  - o_rep_valid=0, o_result_acquired=0, o_overflow_cnt=0.
  - o_rep_sample, o_rep_seq and o_rep_time go to 0.
  - Reset applied mid-operation discards all queued entries; an in-flight acknowledge is not issued.
- Capture FSM:
  - IDLE:
    - If erx_en && i_trigger_peak at edge k: when not full (or full with a pop at the same edge), write {sample, seq, time}; otherwise increment the overflow counter.
    - Go to ACK either way.
  - ACK:
    - o_result_acquired=1 for exactly the cycle after edge k.
    - Go to WAIT_CLR.
  - WAIT_CLR:
    - Stay while i_trigger_peak==1 (the trigger may still be high one cycle after the acknowledge).
    - Go to IDLE when it is 0.
    - No capture happens in this state, so each report is written once.
  - erx_en==0: no new capture starts from IDLE. An ACK or WAIT_CLR already in progress completes. The read side stays fully operational.
- Acknowledge timing: o_result_acquired is registered and asserted only in ACK.
- Queue / read side:
  - First-word-fall-through: an entry written at edge k gives o_rep_valid=1 and the head fields valid after edge k.
  - A pop occurs at an edge where o_rep_valid && i_rep_ready.
  - i_rep_ready while empty has no effect.
  - Head fields are stable while o_rep_valid && !i_rep_ready.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: occupancy is unchanged. When the queue is full, the push is accepted because the pop frees the slot in the same cycle.
  - Empty with simultaneous push and pop cannot occur, because valid is 0.
- Overflow counter:
  - Increments by 1 per dropped report and saturates at all-ones.
  - When i_clear_ovf and an overflow occur at the same edge, the result is 1 (clear, then count).
- Widths:
  - Peak value is stored sign-unaltered.
  - The timestamp is stored verbatim; the block does not handle timestamp wrap.

Decomposition:
- Package rx_peak_pkg:
  - Default widths (SAMPLE_W, SEQ_W, TIME_W, OVF_W).
  - Capture FSM state encodings IDLE=2'd0, ACK=2'd1, WAIT_CLR=2'd2.
  - Packed report width constant REP_W = SAMPLE_W+SEQ_W+TIME_W.
- Sub-module rx_peak_fifo_mem: DEPTH×REP_W storage, read/write pointers, occupancy count, and full/empty flags.
- The top level holds the capture FSM, the overflow counter, and the output unpacking.

Test Plan:
- Reset: hold rrx_rst=0 for 3 cycles with i_trigger_peak=1 -> all outputs are 0 and no acknowledge occurs; after release, o_result_acquired pulses once.
- Single report: sample=-1234, seq=13, time=500 with the trigger held 2 cycles -> exactly one acknowledge cycle, o_rep_count=1, head fields={-1234, 13, 500}; ready=1 pops it -> count=0, valid=0.
- Fill and overflow (DEPTH=8, ready=0): send 10 reports -> count=8, o_overflow_cnt=2, head still holds report #1; drain all 8 -> they come out in order #1..#8.
- Full push+pop: with the queue full, ready=1 at the same edge as a capture -> count stays 8, o_overflow_cnt does not change, and the new entry appears last.
- Enable gating: erx_en=0 with the trigger high for 20 cycles -> no acknowledge and no write; raise erx_en -> one capture and one acknowledge.
- Overflow saturation and clear: force 65537 drops -> counter=0xFFFF; i_clear_ovf coinciding with a drop -> counter=1.

Source files
------------

// File: rtl/rx_peak_pkg.sv
// Shared widths, capture FSM encoding and packed report width for the
// rx_top_level peak-report queue.
package rx_peak_pkg;

    localparam int DEF_SAMPLE_W = 41;
    localparam int DEF_SEQ_W    = 4;
    localparam int DEF_TIME_W   = 32;
    localparam int DEF_OVF_W    = 16;

    localparam int REP_W = DEF_SAMPLE_W + DEF_SEQ_W + DEF_TIME_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } cap_state_t;

endpackage

// File: rtl/rx_peak_fifo_mem.sv
// First-word-fall-through report FIFO: storage, wrapping pointers, occupancy,
// full/empty flags and a registered head word.
module rx_peak_fifo_mem
    import rx_peak_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = REP_W
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       push_req,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_req,
    output logic                       push_accept,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head_data = head_reg;

    assign pop = !empty && pop_req;
    // A full queue still takes a push when the head leaves on the same edge.
    assign push_accept = push_req && (!full || pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;

        if (push_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case ({push_accept, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // The incoming word becomes head when it lands on an empty queue or
        // replaces the only entry; otherwise a pop exposes the next stored word.
        if (push_accept && (empty || (pop && count_reg == CNT_W'(1)))) begin
            head_next = push_data;
        end else if (pop && count_reg > CNT_W'(1)) begin
            head_next = mem[rd_ptr_reg + PTR_W'(1)];
        end
    end

    always_ff @(posedge crx_clk) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge crx_clk) begin
        if (!rrx_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/rx_peak_report_queue.sv
// Acknowledges rx_top_level peak reports, queues them for the ARM reader and
// counts reports dropped on a full queue.
module rx_peak_report_queue
    import rx_peak_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SEQ_W    = DEF_SEQ_W,
    parameter int TIME_W   = DEF_TIME_W,
    parameter int OVF_W    = DEF_OVF_W
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic                       i_trigger_peak,
    input  logic [SAMPLE_W-1:0]        i_sample_peak,
    input  logic [SEQ_W-1:0]           i_seq_peak,
    input  logic [TIME_W-1:0]          i_time_peak,
    output logic                       o_result_acquired,
    output logic                       o_rep_valid,
    input  logic                       i_rep_ready,
    output logic [SAMPLE_W-1:0]        o_rep_sample,
    output logic [SEQ_W-1:0]           o_rep_seq,
    output logic [TIME_W-1:0]          o_rep_time,
    output logic [$clog2(DEPTH+1)-1:0] o_rep_count,
    input  logic                       i_clear_ovf,
    output logic [OVF_W-1:0]           o_overflow_cnt
);

    localparam int DATA_W = SAMPLE_W + SEQ_W + TIME_W;

    cap_state_t state_reg, state_next;
    logic       ack_reg;
    logic [OVF_W-1:0] ovf_reg, ovf_next;

    logic              capture;
    logic              push_accept;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_data;

    assign capture = (state_reg == IDLE) && erx_en && i_trigger_peak;
    assign drop    = capture && !push_accept;

    rx_peak_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .crx_clk     (crx_clk),
        .rrx_rst     (rrx_rst),
        .push_req    (capture),
        .push_data   ({i_sample_peak, i_seq_peak, i_time_peak}),
        .pop_req     (i_rep_ready),
        .push_accept (push_accept),
        .head_data   (head_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (o_rep_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (capture) state_next = ACK;
            ACK:      state_next = WAIT_CLR;
            // The trigger may linger past the acknowledge; wait it out so a
            // report is never captured twice.
            WAIT_CLR: if (!i_trigger_peak) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        ovf_next = i_clear_ovf ? '0 : ovf_reg;
        if (drop && (ovf_next != '1)) begin
            ovf_next = ovf_next + OVF_W'(1);
        end
    end

    always_ff @(posedge crx_clk) begin
        if (!rrx_rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            ovf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= (state_next == ACK);
            ovf_reg   <= ovf_next;
        end
    end

    assign o_result_acquired = ack_reg;
    assign o_overflow_cnt    = ovf_reg;
    assign o_rep_valid       = !fifo_empty;
    assign o_rep_sample      = head_data[DATA_W-1 -: SAMPLE_W];
    assign o_rep_seq         = head_data[TIME_W +: SEQ_W];
    assign o_rep_time        = head_data[TIME_W-1:0];

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
